// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the instruction decoder and a single-port memory.
// Optional request timeout with error pulse is built when MEM_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a load/store instruction
// REQ   | memReq held high until memAck (or timeout)
// WB    | one-cycle write-back of loadData into R0
// DONE  | one-cycle completion, no new request accepted
// ERR   | timeout abort, memErr pulse (MEM_TIMEOUT_EN only)
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr,
  input  logic       instrValid,
  input  logic [7:0] addrVal,
  input  logic [7:0] r0Val,
  input  logic [7:0] memRdata,
  input  logic       memAck,
  output logic       memReq,
  output logic       memWe,
  output logic [7:0] memAddr,
  output logic [7:0] memWdata,
  output logic [7:0] loadData,
  output logic       loadWe,
  output logic       stall,
  output logic       memErr
);

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WB, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_DONE} state_t;
`endif

  localparam logic [4:0] OP_LOAD  = 5'd5;
  localparam logic [4:0] OP_STORE = 5'd6;

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       is_load_q, is_load_d;
  logic [7:0] load_data_q, load_data_d;
  logic       is_ld, is_st;

  assign is_ld = (instr[7:3] == OP_LOAD);
  assign is_st = (instr[7:3] == OP_STORE);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      is_load_q   <= 1'b0;
      load_data_q <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      is_load_q   <= is_load_d;
      load_data_q <= load_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    is_load_d   = is_load_q;
    load_data_d = load_data_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (instrValid && (is_ld || is_st)) begin
          addr_d    = addrVal;
          wdata_d   = r0Val;
          we_d      = is_st;
          is_load_d = is_ld;
          state_d   = S_REQ;
`ifdef MEM_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_REQ: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (memAck) begin
          we_d = 1'b0;
          if (is_load_q) begin
            load_data_d = memRdata;
            state_d     = S_WB;
          end else begin
            state_d = S_DONE;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          we_d    = 1'b0;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
`ifdef MEM_TIMEOUT_EN
      S_ERR:  state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign memReq   = (state_q == S_REQ);
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign loadData = load_data_q;
  assign loadWe   = (state_q == S_WB);

`ifdef MEM_TIMEOUT_EN
  assign memErr = (state_q == S_ERR);
`else
  assign memErr = 1'b0;
`endif

  always_comb begin
    stall = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_IDLE:  stall = instrValid && (is_ld || is_st);
        S_DONE:  stall = 1'b0;
        default: stall = 1'b1;
      endcase
    end
  end

endmodule
